smvm_issue_ctrl: RTL and testbench

Issue controller sitting between the SMVM nonzero input stream and the K-lane multiply/reduce datapath. It accepts one nonzero entry (value, column index, end-of-row flag) per cycle and packs K entries into a lane batch. It issues each batch to the ALU with a valid/ready handshake and zero-pads the final partial batch. It waits out the ALU pipeline latency before signalling completion, and keeps running row and batch counts for the output stage.

---
 rtl/smvm_issue_ctrl_if.sv | 33 +++
 rtl/smvm_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_smvm_issue_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smvm_issue_ctrl_if.sv
// Handshake bundles for the SMVM issue controller: the nonzero input stream
// (source is master) and the lane-batch issue bus (controller is master).
interface smvm_in_if #(
  parameter int VW = 8,
  parameter int CW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_val;
  logic [CW-1:0] in_col;
  logic          in_last;

  modport master (output in_valid, in_val, in_col, in_last, input in_ready);
  modport slave  (input in_valid, in_val, in_col, in_last, output in_ready);
endinterface

interface smvm_issue_if #(
  parameter int K  = 4,
  parameter int VW = 8,
  parameter int CW = 7
);
  logic                       issue_valid;
  logic                       issue_ready;
  logic [K*VW-1:0]            issue_val;
  logic [K*CW-1:0]            issue_col;
  logic [K-1:0]               issue_ipv;
  logic [$clog2(K+1)-1:0]     issue_cnt;

  modport master (output issue_valid, issue_val, issue_col, issue_ipv, issue_cnt,
                  input issue_ready);
  modport slave  (input issue_valid, issue_val, issue_col, issue_ipv, issue_cnt,
                  output issue_ready);
endinterface

// File: rtl/smvm_issue_ctrl.sv
// Packs SMVM nonzeros into K-lane batches, issues them to the ALU with
// zero padding on the final partial batch, then waits out the ALU latency.
module smvm_issue_ctrl #(
  parameter int K       = 4,
  parameter int VW      = 8,
  parameter int CW      = 7,
  parameter int NW      = 10,
  parameter int ALU_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] cfg_nnz,
  smvm_in_if.slave      in_if,
  smvm_issue_if.master  iss_if,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] row_cnt,
  output logic [NW-1:0] batch_cnt
);
  // state | meaning
  // IDLE  | waiting for start, counters hold last matrix results
  // FILL  | accepting entries into lane[ptr]
  // ISSUE | batch presented to ALU, held until issue_ready
  // DRAIN | counting down ALU latency before done
  localparam int PW = $clog2(K + 1);
  localparam int DW = $clog2(ALU_LAT + 2);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NW-1:0]           rem_q, rem_d;
  logic [NW-1:0]           row_q, row_d;
  logic [NW-1:0]           batch_q, batch_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic [K-1:0][VW-1:0]    val_q, val_d;
  logic [K-1:0][CW-1:0]    col_q, col_d;
  logic [K-1:0]            ipv_q, ipv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      row_q   <= '0;
      batch_q <= '0;
      drain_q <= '0;
      val_q   <= '0;
      col_q   <= '0;
      ipv_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
      batch_q <= batch_d;
      drain_q <= drain_d;
      val_q   <= val_d;
      col_q   <= col_d;
      ipv_q   <= ipv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    row_d   = row_q;
    batch_d = batch_q;
    drain_d = drain_q;
    val_d   = val_q;
    col_d   = col_q;
    ipv_d   = ipv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = cfg_nnz;
          row_d   = '0;
          batch_d = '0;
          ptr_d   = '0;
          val_d   = '0;
          col_d   = '0;
          ipv_d   = '0;
          if (cfg_nnz != '0) begin
            state_d = FILL;
          end else begin
            // empty matrix spends one extra cycle so done lands at start+ALU_LAT+2
            state_d = DRAIN;
            drain_d = DW'(ALU_LAT + 1);
          end
        end
      end
      FILL: begin
        if (in_if.in_valid) begin
          for (int i = 0; i < K; i++) begin
            if (ptr_q == PW'(i)) begin
              val_d[i] = in_if.in_val;
              col_d[i] = in_if.in_col;
              ipv_d[i] = in_if.in_last;
            end
          end
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (in_if.in_last) row_d = row_q + 1'b1;
          if ((ptr_d == PW'(K)) || (rem_d == '0)) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (iss_if.issue_ready) begin
          batch_d = batch_q + 1'b1;
          ptr_d   = '0;
          val_d   = '0;
          col_d   = '0;
          ipv_d   = '0;
          if (rem_q != '0) begin
            state_d = FILL;
          end else begin
            state_d = DRAIN;
            drain_d = DW'(ALU_LAT);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = IDLE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // unfilled lanes are already zero because lanes clear on every transfer and start
  assign in_if.in_ready     = (state_q == FILL);
  assign iss_if.issue_valid = (state_q == ISSUE);
  assign iss_if.issue_val   = val_q;
  assign iss_if.issue_col   = col_q;
  assign iss_if.issue_ipv   = ipv_q;
  assign iss_if.issue_cnt   = (state_q == ISSUE) ? ptr_q : '0;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && (drain_q == '0);
  assign row_cnt   = row_q;
  assign batch_cnt = batch_q;
endmodule

// File: tb/tb_smvm_issue_ctrl.sv
// Directed bench for smvm_issue_ctrl: batching, padding, backpressure,
// empty matrix, ignored restarts and mid-run reset.
module tb_smvm_issue_ctrl;
  localparam int K       = 4;
  localparam int VW      = 8;
  localparam int CW      = 7;
  localparam int NW      = 10;
  localparam int ALU_LAT = 4;
  localparam int PW      = $clog2(K + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] cfg_nnz = '0;
  logic          busy, done;
  logic [NW-1:0] row_cnt, batch_cnt;

  smvm_in_if    #(.VW(VW), .CW(CW))         in_bus ();
  smvm_issue_if #(.K(K), .VW(VW), .CW(CW))  iss_bus ();

  smvm_issue_ctrl #(.K(K), .VW(VW), .CW(CW), .NW(NW), .ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_nnz   (cfg_nnz),
    .in_if     (in_bus),
    .iss_if    (iss_bus),
    .busy      (busy),
    .done      (done),
    .row_cnt   (row_cnt),
    .batch_cnt (batch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  logic [VW-1:0] e_val  [16];
  logic [CW-1:0] e_col  [16];
  logic          e_last [16];

  int               nb, nvalid, n_acc, unstable, inr_bad, stall_seen, start_cyc, done_cyc;
  bit               done_seen, rdy1, busy1, post_busy, post_done;
  logic [K*VW-1:0]  b_val [8];
  logic [K*CW-1:0]  b_col [8];
  logic [K-1:0]     b_ipv [8];
  logic [PW-1:0]    b_cnt [8];
  int               xfer_cyc [8];

  task automatic load(input logic [VW-1:0] v0, input logic [CW-1:0] c0, input logic [15:0] lastm);
    for (int i = 0; i < 16; i++) begin
      e_val[i]  = v0 + VW'(i);
      e_col[i]  = c0 + CW'(i);
      e_last[i] = lastm[i];
    end
  endtask

  // Drives one matrix end to end, capturing every transferred batch.
  task automatic run_matrix(input int nnz, input int stall, input bit pf, input bit pd);
    int stall_left;
    bit snap, pf_done, pd_done;
    logic [K*VW-1:0] sv;
    logic [K*CW-1:0] sc;
    logic [K-1:0]    si;
    logic [PW-1:0]   sn;
    nb = 0; nvalid = 0; n_acc = 0; unstable = 0; inr_bad = 0; stall_seen = 0;
    done_seen = 0; done_cyc = -1; snap = 0; pf_done = 0; pd_done = 0;
    stall_left = stall;
    @(negedge clk);
    start = 1'b1;
    cfg_nnz = NW'(nnz);
    start_cyc = cyc;
    in_bus.in_valid = 1'b0;
    iss_bus.issue_ready = (stall == 0);
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rdy1  = in_bus.in_ready;
        busy1 = busy;
      end
      start = 1'b0;
      cfg_nnz = NW'(3);
      if (pf && !pf_done && in_bus.in_ready) begin start = 1'b1; pf_done = 1; end
      if (pd && !pd_done && busy && !in_bus.in_ready && !iss_bus.issue_valid) begin
        start = 1'b1;
        pd_done = 1;
      end
      if (done) begin done_seen = 1; done_cyc = cyc; end
      if (n_acc < nnz) begin
        in_bus.in_valid = 1'b1;
        in_bus.in_val   = e_val[n_acc];
        in_bus.in_col   = e_col[n_acc];
        in_bus.in_last  = e_last[n_acc];
      end else begin
        in_bus.in_valid = 1'b0;
      end
      if (in_bus.in_valid && in_bus.in_ready) n_acc++;
      if (iss_bus.issue_valid) begin
        nvalid++;
        if (stall_left > 0) begin
          stall_seen++;
          stall_left--;
          if (!snap) begin
            snap = 1;
            sv = iss_bus.issue_val; sc = iss_bus.issue_col;
            si = iss_bus.issue_ipv; sn = iss_bus.issue_cnt;
          end else if ({iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt}
                       !== {sv, sc, si, sn}) begin
            unstable++;
          end
          if (in_bus.in_ready) inr_bad++;
          iss_bus.issue_ready = 1'b0;
        end else begin
          if (snap && nb == 0 &&
              {iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt}
              !== {sv, sc, si, sn}) unstable++;
          iss_bus.issue_ready = 1'b1;
          if (nb < 8) begin
            b_val[nb] = iss_bus.issue_val;
            b_col[nb] = iss_bus.issue_col;
            b_ipv[nb] = iss_bus.issue_ipv;
            b_cnt[nb] = iss_bus.issue_cnt;
            xfer_cyc[nb] = cyc;
          end
          nb++;
        end
      end else begin
        iss_bus.issue_ready = (stall_left == 0);
      end
    end
    @(negedge clk);
    post_busy = busy;
    post_done = done;
    start = 1'b0;
    in_bus.in_valid = 1'b0;
    iss_bus.issue_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_bus.in_ready, iss_bus.issue_valid, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 0000", {in_bus.in_ready, iss_bus.issue_valid, busy, done});
    end
    n_checks++;
    if ({iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_issue_bus: got %h required 0",
               {iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt});
    end
    n_checks++;
    if ({row_cnt, batch_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_counters: got row=%0d batch=%0d required 0/0", row_cnt, batch_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    load(8'h10, 7'h20, 16'h0088);
    run_matrix(8, 0, 0, 0);
    n_checks++;
    if (!done_seen) begin n_err++; $display("FAIL b2b_done_timeout: no done within budget"); end
    n_checks++;
    if (nb !== 2) begin n_err++; $display("FAIL b2b_batches: got %0d required 2", nb); end
    n_checks++;
    if (b_val[0] !== 32'h13121110) begin n_err++; $display("FAIL b2b_b0_val: got %h required 13121110", b_val[0]); end
    n_checks++;
    if (b_col[0] !== {7'h23, 7'h22, 7'h21, 7'h20}) begin
      n_err++; $display("FAIL b2b_b0_col: got %h required %h", b_col[0], {7'h23, 7'h22, 7'h21, 7'h20});
    end
    n_checks++;
    if ({b_ipv[0], b_cnt[0]} !== {4'b1000, 3'd4}) begin
      n_err++; $display("FAIL b2b_b0_ipv_cnt: got ipv=%b cnt=%0d required 1000/4", b_ipv[0], b_cnt[0]);
    end
    n_checks++;
    if (b_val[1] !== 32'h17161514) begin n_err++; $display("FAIL b2b_b1_val: got %h required 17161514", b_val[1]); end
    n_checks++;
    if (b_col[1] !== {7'h27, 7'h26, 7'h25, 7'h24}) begin
      n_err++; $display("FAIL b2b_b1_col: got %h required %h", b_col[1], {7'h27, 7'h26, 7'h25, 7'h24});
    end
    n_checks++;
    if ({b_ipv[1], b_cnt[1]} !== {4'b1000, 3'd4}) begin
      n_err++; $display("FAIL b2b_b1_ipv_cnt: got ipv=%b cnt=%0d required 1000/4", b_ipv[1], b_cnt[1]);
    end
    n_checks++;
    if ({rdy1, busy1} !== 2'b11) begin n_err++; $display("FAIL b2b_start_latency: got rdy,busy=%b required 11", {rdy1, busy1}); end
    n_checks++;
    if (xfer_cyc[0] - start_cyc !== 5) begin
      n_err++; $display("FAIL b2b_first_xfer: got %0d cycles after start required 5", xfer_cyc[0] - start_cyc);
    end
    n_checks++;
    if (xfer_cyc[1] - xfer_cyc[0] !== K + 1) begin
      n_err++; $display("FAIL b2b_throughput: got %0d cycles per batch required %0d", xfer_cyc[1] - xfer_cyc[0], K + 1);
    end
    n_checks++;
    if (done_cyc - xfer_cyc[1] !== ALU_LAT + 1) begin
      n_err++; $display("FAIL b2b_done_latency: got %0d required %0d", done_cyc - xfer_cyc[1], ALU_LAT + 1);
    end
    n_checks++;
    if ({post_busy, post_done} !== 2'b00) begin
      n_err++; $display("FAIL b2b_after_done: got busy,done=%b required 00", {post_busy, post_done});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({row_cnt, batch_cnt} !== {10'd2, 10'd2}) begin
      n_err++; $display("FAIL b2b_idle_hold: got row=%0d batch=%0d required 2/2", row_cnt, batch_cnt);
    end
  endtask

  task automatic test_partial_rows();
    load(8'hF0, 7'h30, 16'h0032);
    run_matrix(6, 0, 0, 0);
    n_checks++;
    if (!done_seen || nb !== 2) begin
      n_err++; $display("FAIL rows_batches: got done=%0d batches=%0d required 1/2", done_seen, nb);
    end
    n_checks++;
    if ({b_val[0], b_ipv[0], b_cnt[0]} !== {32'hF3F2F1F0, 4'b0010, 3'd4}) begin
      n_err++; $display("FAIL rows_b0: got val=%h ipv=%b cnt=%0d required F3F2F1F0/0010/4", b_val[0], b_ipv[0], b_cnt[0]);
    end
    n_checks++;
    if ({b_val[1], b_ipv[1], b_cnt[1]} !== {32'h0000F5F4, 4'b0011, 3'd2}) begin
      n_err++; $display("FAIL rows_b1: got val=%h ipv=%b cnt=%0d required 0000F5F4/0011/2", b_val[1], b_ipv[1], b_cnt[1]);
    end
    n_checks++;
    if (b_col[1] !== {7'h00, 7'h00, 7'h35, 7'h34}) begin
      n_err++; $display("FAIL rows_b1_col_pad: got %h required %h", b_col[1], {7'h00, 7'h00, 7'h35, 7'h34});
    end
    n_checks++;
    if ({row_cnt, batch_cnt} !== {10'd3, 10'd2}) begin
      n_err++; $display("FAIL rows_counts: got row=%0d batch=%0d required 3/2", row_cnt, batch_cnt);
    end
    n_checks++;
    if (done_cyc - xfer_cyc[1] !== ALU_LAT + 1) begin
      n_err++; $display("FAIL rows_done_latency: got %0d required %0d", done_cyc - xfer_cyc[1], ALU_LAT + 1);
    end
  endtask

  task automatic test_backpressure();
    load(8'h10, 7'h20, 16'h0088);
    run_matrix(8, 7, 0, 0);
    n_checks++;
    if (stall_seen !== 7 || unstable !== 0 || inr_bad !== 0) begin
      n_err++; $display("FAIL bp_hold: got stall=%0d unstable=%0d in_ready_high=%0d required 7/0/0", stall_seen, unstable, inr_bad);
    end
    n_checks++;
    if (!done_seen || nb !== 2 || n_acc !== 8) begin
      n_err++; $display("FAIL bp_flow: got done=%0d batches=%0d accepted=%0d required 1/2/8", done_seen, nb, n_acc);
    end
    n_checks++;
    if ({b_val[0], b_val[1]} !== {32'h13121110, 32'h17161514}) begin
      n_err++; $display("FAIL bp_vals: got %h %h required 13121110 17161514", b_val[0], b_val[1]);
    end
    n_checks++;
    if ({b_col[1], b_ipv[0], b_ipv[1], b_cnt[0], b_cnt[1]} !== {7'h27, 7'h26, 7'h25, 7'h24, 4'b1000, 4'b1000, 3'd4, 3'd4}) begin
      n_err++; $display("FAIL bp_meta: got col=%h ipv=%b/%b cnt=%0d/%0d", b_col[1], b_ipv[0], b_ipv[1], b_cnt[0], b_cnt[1]);
    end
    n_checks++;
    if (xfer_cyc[0] - start_cyc !== 12) begin
      n_err++; $display("FAIL bp_first_xfer: got %0d required 12", xfer_cyc[0] - start_cyc);
    end
    n_checks++;
    if ({row_cnt, batch_cnt} !== {10'd2, 10'd2}) begin
      n_err++; $display("FAIL bp_counts: got row=%0d batch=%0d required 2/2", row_cnt, batch_cnt);
    end
  endtask

  task automatic test_empty();
    run_matrix(0, 0, 0, 0);
    n_checks++;
    if (!done_seen || done_cyc - start_cyc !== ALU_LAT + 2) begin
      n_err++; $display("FAIL empty_done: got seen=%0d at %0d required %0d", done_seen, done_cyc - start_cyc, ALU_LAT + 2);
    end
    n_checks++;
    if (nvalid !== 0 || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
      n_err++; $display("FAIL empty_flow: got valid_cycles=%0d busy=%0d ready=%0d required 0/1/0", nvalid, busy1, rdy1);
    end
    n_checks++;
    if ({row_cnt, batch_cnt} !== '0) begin
      n_err++; $display("FAIL empty_counts: got row=%0d batch=%0d required 0/0", row_cnt, batch_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    load(8'h10, 7'h20, 16'h0088);
    run_matrix(8, 0, 1, 1);
    n_checks++;
    if (!done_seen || nb !== 2 || done_cyc - start_cyc !== 15) begin
      n_err++; $display("FAIL restart_flow: got done=%0d batches=%0d done_at=%0d required 1/2/15", done_seen, nb, done_cyc - start_cyc);
    end
    n_checks++;
    if ({b_val[0], b_val[1]} !== {32'h13121110, 32'h17161514}) begin
      n_err++; $display("FAIL restart_vals: got %h %h required 13121110 17161514", b_val[0], b_val[1]);
    end
    n_checks++;
    if ({row_cnt, batch_cnt, post_busy} !== {10'd2, 10'd2, 1'b0}) begin
      n_err++; $display("FAIL restart_counts: got row=%0d batch=%0d busy=%0d required 2/2/0", row_cnt, batch_cnt, post_busy);
    end
  endtask

  task automatic test_reset_mid();
    load(8'h10, 7'h20, 16'h0088);
    @(negedge clk);
    start = 1'b1;
    cfg_nnz = NW'(8);
    iss_bus.issue_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_bus.in_valid = 1'b1;
      in_bus.in_val   = e_val[i];
      in_bus.in_col   = e_col[i];
      in_bus.in_last  = e_last[i];
      @(negedge clk);
    end
    in_bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({iss_bus.issue_valid, iss_bus.issue_cnt, row_cnt} !== {1'b1, 3'd4, 10'd1}) begin
      n_err++; $display("FAIL rstmid_pre: got valid=%0d cnt=%0d row=%0d required 1/4/1", iss_bus.issue_valid, iss_bus.issue_cnt, row_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_bus.in_ready, iss_bus.issue_valid, busy, done} !== 4'b0) begin
      n_err++; $display("FAIL rstmid_ctrl: got %b required 0000", {in_bus.in_ready, iss_bus.issue_valid, busy, done});
    end
    n_checks++;
    if ({iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt, row_cnt, batch_cnt} !== '0) begin
      n_err++; $display("FAIL rstmid_data: got val=%h col=%h ipv=%b cnt=%0d row=%0d batch=%0d required all 0",
                        iss_bus.issue_val, iss_bus.issue_col, iss_bus.issue_ipv, iss_bus.issue_cnt, row_cnt, batch_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_matrix(4, 0, 0, 0);
    n_checks++;
    if (!done_seen || nb !== 1) begin
      n_err++; $display("FAIL rstmid_rerun: got done=%0d batches=%0d required 1/1", done_seen, nb);
    end
    n_checks++;
    if ({b_val[0], b_ipv[0], b_cnt[0]} !== {32'h13121110, 4'b1000, 3'd4}) begin
      n_err++; $display("FAIL rstmid_batch: got val=%h ipv=%b cnt=%0d required 13121110/1000/4", b_val[0], b_ipv[0], b_cnt[0]);
    end
    n_checks++;
    if ({row_cnt, batch_cnt} !== {10'd1, 10'd1}) begin
      n_err++; $display("FAIL rstmid_counts: got row=%0d batch=%0d required 1/1", row_cnt, batch_cnt);
    end
  endtask

  initial begin
    in_bus.in_valid = 1'b0;
    in_bus.in_val   = '0;
    in_bus.in_col   = '0;
    in_bus.in_last  = 1'b0;
    iss_bus.issue_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_partial_rows();
    test_backpressure();
    test_empty();
    test_restart_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
